// File: rtl/sp_stage_seq.sv
// Frame sequencer for the SP datapath. It loads one frame, runs the stages selected by the
// mode one after another, and then streams the frame out. It also drives the ICG enables.
module sp_stage_seq #(
    parameter int FRAME_LEN = 9,
    parameter int IDX_W     = 4,
    parameter int NUM_STG   = 3,
    parameter int STG_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               cg_en,
    input  logic [NUM_STG-1:0] in_mode,
    output logic               ld_en,
    output logic [IDX_W-1:0]   ld_idx,
    output logic [NUM_STG-1:0] mode_q,
    output logic [NUM_STG-1:0] stg_act,
    output logic               stg_first,
    output logic               rd_en,
    output logic [IDX_W-1:0]   rd_idx,
    output logic               out_last,
    output logic               busy,
    output logic               frame_err,
    output logic [NUM_STG+1:0] gate_en
);

    localparam int CYC_W = (STG_CYC > 1) ? $clog2(STG_CYC) : 1;
    localparam int STG_W = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(STG_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STG, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [IDX_W-1:0]   ld_idx_q, ld_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [NUM_STG-1:0] mode_d;
    logic [NUM_STG-1:0] stg_act_q, stg_act_d;
    logic               stg_first_q, stg_first_d;
    logic               rd_en_q, rd_en_d;
    logic               out_last_q, out_last_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic [STG_W:0]     first_sel, next_sel;

    // Returns {found, index} of the lowest selected stage at or above 'from'.
    function automatic logic [STG_W:0] find_stage(input logic [NUM_STG-1:0] mode, input int from);
        logic [STG_W:0] res;
        res = '0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (mode[k] && (k >= from)) begin
                res = {1'b1, STG_W'(k)};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        stg_d       = stg_q;
        cyc_d       = cyc_q;
        ld_idx_d    = ld_idx_q;
        rd_idx_d    = rd_idx_q;
        mode_d      = mode_q;
        frame_err_d = 1'b0;
        ld_en       = 1'b0;
        first_sel   = find_stage(mode_q, 0);
        next_sel    = find_stage(mode_q, int'(stg_q) + 1);

        case (state_q)
            S_IDLE: begin
                if (in_valid && rst_n) begin
                    ld_en    = 1'b1;
                    mode_d   = in_mode;
                    ld_idx_d = IDX_W'(1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!in_valid) begin
                    state_d     = S_IDLE;
                    ld_idx_d    = '0;
                    frame_err_d = 1'b1;
                end else begin
                    ld_en = 1'b1;
                    if (ld_idx_q == LAST_IDX) begin
                        if (first_sel[STG_W]) begin
                            state_d = S_STG;
                            stg_d   = first_sel[STG_W-1:0];
                            cyc_d   = '0;
                        end else begin
                            state_d = S_OUT;
                        end
                    end else begin
                        ld_idx_d = ld_idx_q + IDX_W'(1);
                    end
                end
            end
            S_STG: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    if (next_sel[STG_W]) begin
                        stg_d = next_sel[STG_W-1:0];
                    end else begin
                        state_d = S_OUT;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_OUT: begin
                if (rd_idx_q == LAST_IDX) begin
                    state_d  = S_IDLE;
                    rd_idx_d = '0;
                    ld_idx_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Moore outputs are decoded from the next state so they appear registered.
        stg_act_d   = (state_d == S_STG) ? (NUM_STG'(1) << stg_d) : '0;
        stg_first_d = (state_d == S_STG) && (cyc_d == '0);
        rd_en_d     = (state_d == S_OUT);
        out_last_d  = (state_d == S_OUT) && (rd_idx_d == LAST_IDX);
        busy_d      = (state_d != S_IDLE);
    end

    always_comb begin
        gate_en[0] = ~cg_en | ld_en;
        for (int k = 0; k < NUM_STG; k++) begin
            gate_en[k+1] = ~cg_en | stg_act_q[k] | ((state_d == S_STG) && (stg_d == STG_W'(k)));
        end
        gate_en[NUM_STG+1] = ~cg_en | rd_en_q | (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stg_q       <= '0;
            cyc_q       <= '0;
            ld_idx_q    <= '0;
            rd_idx_q    <= '0;
            mode_q      <= '0;
            stg_act_q   <= '0;
            stg_first_q <= 1'b0;
            rd_en_q     <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_q       <= stg_d;
            cyc_q       <= cyc_d;
            ld_idx_q    <= ld_idx_d;
            rd_idx_q    <= rd_idx_d;
            mode_q      <= mode_d;
            stg_act_q   <= stg_act_d;
            stg_first_q <= stg_first_d;
            rd_en_q     <= rd_en_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ld_idx    = ld_idx_q;
    assign rd_idx    = rd_idx_q;
    assign stg_act   = stg_act_q;
    assign stg_first = stg_first_q;
    assign rd_en     = rd_en_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
